// File: rtl/input_debouncer.sv
// ----------------------------------------------------------------------------
// input_debouncer
//
// Turns a raw, asynchronous, bouncing input into a clean, clock-synchronous
// level. A synchronizer chain feeds a four-state filter that flips the output
// only after STABLE_CYCLES consecutive enabled samples disagree with it.
// Aborted transitions are reported as a one-cycle glitch pulse and counted
// in a saturating 8-bit debug counter.
//
// Parameters:
//   SYNC_STAGES    synchronizer depth (>= 2)
//   STABLE_CYCLES  consecutive enabled samples needed to flip (>= 1)
//
// Ports:
//   clk           in   single clock, all logic on posedge
//   reset         in   synchronous, active-high reset
//   en_i          in   sample enable; tie high to sample every cycle
//   a_i           in   raw asynchronous input
//   glitch_clr_i  in   clears glitch_cnt_o (independent of en_i)
//   a_db_o        out  debounced level (decoded from state register)
//   busy_o        out  high while a transition is being qualified
//   glitch_o      out  one-cycle pulse after an aborted transition
//   glitch_cnt_o  out  saturating count of aborted transitions
// ----------------------------------------------------------------------------
module input_debouncer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic       a_i,
    input  logic       glitch_clr_i,
    output logic       a_db_o,
    output logic       busy_o,
    output logic       glitch_o,
    output logic [7:0] glitch_cnt_o
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_CYCLES - 1);

    // Bit 1 of the encoding equals the debounced level.
    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        CHECK_HIGH  = 2'b01,
        STABLE_HIGH = 2'b11,
        CHECK_LOW   = 2'b10
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    logic                   w_abort;
    logic                   r_glitch;
    logic [7:0]             r_glitch_cnt;

    // ------------------------------------------------------------------
    // Synchronizer: runs every cycle so the enabled samples always see a
    // fully settled value.
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours (the shift works).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], a_i};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // FSM state register (includes the stability counter).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= STABLE_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. Only enabled cycles advance; otherwise hold.
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_abort     = 1'b0;
        if (en_i) begin
            case (r_state)
                STABLE_LOW: begin
                    if (w_s) begin
                        if (STABLE_CYCLES == 1) begin
                            w_state_nxt = STABLE_HIGH;
                        end else begin
                            w_state_nxt = CHECK_HIGH;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                CHECK_HIGH: begin
                    if (w_s) begin
                        if (r_cnt == LAST_CNT) begin
                            w_state_nxt = STABLE_HIGH;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_nxt = STABLE_LOW;
                        w_cnt_nxt   = '0;
                        w_abort     = 1'b1;
                    end
                end
                STABLE_HIGH: begin
                    if (!w_s) begin
                        if (STABLE_CYCLES == 1) begin
                            w_state_nxt = STABLE_LOW;
                        end else begin
                            w_state_nxt = CHECK_LOW;
                            w_cnt_nxt   = CNT_W'(1);
                        end
                    end
                end
                CHECK_LOW: begin
                    if (!w_s) begin
                        if (r_cnt == LAST_CNT) begin
                            w_state_nxt = STABLE_LOW;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + CNT_W'(1);
                        end
                    end else begin
                        w_state_nxt = STABLE_HIGH;
                        w_cnt_nxt   = '0;
                        w_abort     = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = STABLE_LOW;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Glitch pulse and saturating counter. Clear wins over the old value
    // but a coincident glitch still counts (clear, then count).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_glitch     <= 1'b0;
            r_glitch_cnt <= 8'd0;
        end else begin
            r_glitch <= w_abort;
            if (glitch_clr_i) begin
                r_glitch_cnt <= w_abort ? 8'd1 : 8'd0;
            end else if (w_abort && (r_glitch_cnt != 8'hFF)) begin
                r_glitch_cnt <= r_glitch_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode: purely from registers, no input-to-output path.
    // ------------------------------------------------------------------
    always_comb begin
        a_db_o = 1'b0;
        busy_o = 1'b0;
        case (r_state)
            STABLE_LOW:  begin a_db_o = 1'b0; busy_o = 1'b0; end
            CHECK_HIGH:  begin a_db_o = 1'b0; busy_o = 1'b1; end
            STABLE_HIGH: begin a_db_o = 1'b1; busy_o = 1'b0; end
            CHECK_LOW:   begin a_db_o = 1'b1; busy_o = 1'b1; end
            default:     begin a_db_o = 1'b0; busy_o = 1'b0; end
        endcase
    end

    assign glitch_o     = r_glitch;
    assign glitch_cnt_o = r_glitch_cnt;

endmodule

// File: tb/tb_input_debouncer.sv
// ----------------------------------------------------------------------------
// tb_input_debouncer
//
// Self-checking bench for input_debouncer with SYNC_STAGES=2, STABLE_CYCLES=4.
// Each applied cycle pushes its expected outputs onto a scoreboard queue; the
// entry is popped and compared 1 ns after the clock edge that produces it.
// Step k drives the inputs sampled at edge k and checks the outputs after
// edge k. With two sync stages the FSM at edge k sees a_i from edge k-2.
// ----------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 4;

    typedef struct packed {
        logic       db;
        logic       busy;
        logic       gl;
        logic [7:0] cnt;
    } exp_t;

    typedef struct packed {
        logic rst;
        logic en;
        logic a;
        logic clr;
        exp_t e;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       en_i;
    logic       a_i;
    logic       glitch_clr_i;
    logic       a_db_o;
    logic       busy_o;
    logic       glitch_o;
    logic [7:0] glitch_cnt_o;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    vec_t vecs[$];

    input_debouncer #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .en_i        (en_i),
        .a_i         (a_i),
        .glitch_clr_i(glitch_clr_i),
        .a_db_o      (a_db_o),
        .busy_o      (busy_o),
        .glitch_o    (glitch_o),
        .glitch_cnt_o(glitch_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input exp_t act, input exp_t exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got db=%b busy=%b gl=%b cnt=%0d, want db=%b busy=%b gl=%b cnt=%0d",
                     name, act.db, act.busy, act.gl, act.cnt,
                     exp.db, exp.busy, exp.gl, exp.cnt);
        end
    endtask

    // Drive one cycle, queue its expectation, compare after the edge.
    task automatic step(input logic rst, input logic en, input logic a, input logic clr,
                        input exp_t e, input string name);
        exp_t got;
        reset        = rst;
        en_i         = en;
        a_i          = a;
        glitch_clr_i = clr;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check(name, {a_db_o, busy_o, glitch_o, glitch_cnt_o}, got);
    endtask

    task automatic stepx(input logic rst, input logic en, input logic a, input logic clr,
                         input logic db, input logic busy, input logic gl, input int cnt,
                         input string tag, input int idx);
        exp_t e;
        e.db   = db;
        e.busy = busy;
        e.gl   = gl;
        e.cnt  = 8'(cnt);
        step(rst, en, a, clr, e, $sformatf("%s[%0d]", tag, idx));
    endtask

    function automatic void add(logic rst, logic en, logic a, logic clr,
                                logic db, logic busy, logic gl, int cnt);
        vec_t v;
        v.rst    = rst;
        v.en     = en;
        v.a      = a;
        v.clr    = clr;
        v.e.db   = db;
        v.e.busy = busy;
        v.e.gl   = gl;
        v.e.cnt  = 8'(cnt);
        vecs.push_back(v);
    endfunction

    // Clean step with en_i=1: busy after edges 2..4, level flips after edge 5.
    function automatic void add_step(logic a_new, logic db_old);
        for (int k = 0; k < 6; k++) begin
            add(0, 1, a_new, 0, (k == 5) ? a_new : db_old, (k >= 2 && k <= 4), 0, 0);
        end
    endfunction

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b1;
        en_i         = 1'b1;
        a_i          = 1'b1;
        glitch_clr_i = 1'b0;

        // ---------------- vector table ----------------
        // Reset held 3 cycles with a_i=1: everything stays 0.
        for (int k = 0; k < 3; k++) add(1, 1, 1, 0, 0, 0, 0, 0);
        // Release: rise counted from the first post-reset edge.
        add_step(1, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        // Clean fall.
        add_step(0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        // Bounce 1,1,0,1,1,1,1 (then held 1): abort at edge 4, restart
        // with the sample from edge 3, so the level rises after edge 8.
        add(0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 0, 1, 0, 1);
        add(0, 1, 1, 0, 1, 0, 0, 1);
        add(0, 1, 1, 0, 1, 0, 0, 1);
        // Clear works with en_i low.
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        // Aborted fall (CHECK_LOW side): 0 then back to 1.
        add(0, 1, 0, 0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 1, 0, 0);
        add(0, 1, 1, 0, 1, 0, 1, 1);
        add(0, 1, 1, 0, 1, 0, 0, 1);
        add(0, 1, 1, 0, 1, 0, 0, 1);
        add(0, 1, 1, 1, 1, 0, 0, 0);
        // Low pulse entirely between ticks is invisible.
        for (int k = 0; k < 6; k++) add(0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0);
        add(0, 0, 1, 0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        add(0, 1, 1, 0, 1, 0, 0, 0);
        // Clean fall back to low.
        add_step(0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].a, vecs[i].clr, vecs[i].e,
                 $sformatf("vec[%0d]", i));
        end

        // ---------------- enable gating ----------------
        // en_i on every 4th cycle (c=3,7,11,15,...); the FSM sees s=1 from
        // edge 2 on, so the 4th enabled sample is edge 15.
        begin
            int n_en;
            logic en;
            n_en = 0;
            for (int c = 0; c < 20; c++) begin
                en = ((c % 4) == 3);
                if (en && c >= 2) n_en++;
                stepx(0, en, 1, 0, (n_en >= 4), (n_en >= 1 && n_en <= 3), 0, 0, "gate", c);
            end
        end

        // ---------------- saturation ----------------
        // From STABLE_HIGH, a_i alternates 0,1: every odd edge from 3 on
        // aborts a CHECK_LOW. 519..521 gives 260 aborts in total.
        for (int k = 0; k < 522; k++) begin
            int n;
            n = (k >= 3) ? (k - 1) / 2 : 0;
            stepx(0, 1, (k % 2 == 1), 0, 1, (k >= 2 && k % 2 == 0), (k >= 3 && k % 2 == 1),
                  (n > 255) ? 255 : n, "sat", k);
        end
        stepx(0, 1, 1, 0, 1, 1, 0, 255, "sat_chk", 0);
        stepx(0, 1, 1, 1, 1, 0, 1, 1,   "clr_with_glitch", 0);
        stepx(0, 1, 1, 1, 1, 0, 0, 0,   "clr_alone", 0);
        stepx(0, 1, 1, 0, 1, 0, 0, 0,   "clr_after", 0);

        // ---------------- reset mid-CHECK ----------------
        for (int k = 0; k < 6; k++) stepx(0, 1, 0, 0, (k != 5), (k >= 2 && k <= 4), 0, 0, "fall2", k);
        stepx(0, 1, 0, 0, 0, 0, 0, 0, "fall2_hold", 0);
        stepx(0, 1, 0, 0, 0, 0, 0, 0, "fall2_hold", 1);
        // Edges 2,3 bring CHECK_HIGH to cnt=2; reset on the next edge.
        for (int k = 0; k < 4; k++) stepx(0, 1, 1, 0, 0, (k >= 2), 0, 0, "rise_pre", k);
        stepx(1, 1, 1, 0, 0, 0, 0, 0, "mid_rst", 0);
        // Full qualification restarts from a cleared synchronizer and counter.
        for (int k = 0; k < 6; k++) stepx(0, 1, 1, 0, (k == 5), (k >= 2 && k <= 4), 0, 0, "post_rst", k);
        stepx(0, 1, 1, 0, 1, 0, 0, 0, "post_rst_hold", 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
